// File: rtl/ext_irq_arb.sv
// ext_irq_arb: per-source interrupt gateways, priority/threshold arbiter and claim/complete registers.
// Define EXT_IRQ_EDGE_EN for rising-edge gateways; the default build uses level-triggered gateways.
`ifndef REG_BUS_D
`define REG_BUS_D 32
`endif

module ext_irq_arb #(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3
) (
   input  logic                   clk_i,
   input  logic                   n_rst_i,
   input  logic [NUM_SRC-1:0]     irq_src_i,
   input  logic                   reg_re_i,
   input  logic                   reg_we_i,
   input  logic [3:0]             reg_addr_i,
   input  logic [`REG_BUS_D-1:0]  reg_wdata_i,
   output logic [`REG_BUS_D-1:0]  reg_rdata_o,
   output logic                   reg_ready_o,
   output logic                   ext_irq_o
);

   localparam int DW    = `REG_BUS_D;
   localparam int NPRIO = (NUM_SRC < 8) ? NUM_SRC : 8;
   localparam logic [3:0] A_PEND  = 4'd8;
   localparam logic [3:0] A_EN    = 4'd9;
   localparam logic [3:0] A_THR   = 4'd10;
   localparam logic [3:0] A_CLAIM = 4'd11;

   typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_FLIGHT} gw_e;

   gw_e               gw_q   [NUM_SRC];
   gw_e               gw_d   [NUM_SRC];
   logic [PRIO_W-1:0] prio_q [NUM_SRC];
   logic [PRIO_W-1:0] prio_d [NUM_SRC];
   logic [NUM_SRC-1:0] en_q, en_d;
   logic [PRIO_W-1:0]  thr_q, thr_d;
   logic [DW-1:0]      rdata_q, rdata_d;
   logic               ready_q, ready_d;
   logic               irq_q;
   logic               act_q;

   logic [NUM_SRC-1:0] trig;
   logic [NUM_SRC-1:0] pend_vec;
   logic [PRIO_W-1:0]  best;
   logic [3:0]         win_id;
   logic               win_vld;
   logic               wr, rd;

`ifdef EXT_IRQ_EDGE_EN
   logic [NUM_SRC-1:0] hist_q;

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) hist_q <= '0;
      else          hist_q <= irq_src_i;
   end

   assign trig = irq_src_i & ~hist_q;
`else
   assign trig = irq_src_i;
`endif

   // Accesses are ignored on the first edge after reset release.
   assign wr = act_q & reg_we_i;
   assign rd = act_q & reg_re_i & ~reg_we_i;

   // Starting from THRESHOLD with a strict compare gives "above threshold" and lowest-ID tie-break.
   always_comb begin
      best    = thr_q;
      win_id  = '0;
      win_vld = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (gw_q[k] == GW_PEND && en_q[k] && prio_q[k] > best) begin
            best    = prio_q[k];
            win_id  = 4'(k + 1);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      pend_vec = '0;
      for (int k = 0; k < NUM_SRC; k++) pend_vec[k] = (gw_q[k] == GW_PEND);
   end

   always_comb begin
      en_d    = en_q;
      thr_d   = thr_q;
      rdata_d = '0;
      ready_d = wr | rd;
      for (int k = 0; k < NUM_SRC; k++) begin
         gw_d[k]   = gw_q[k];
         prio_d[k] = prio_q[k];
      end

      for (int k = 0; k < NUM_SRC; k++) begin
         case (gw_q[k])
            GW_IDLE:   if (trig[k]) gw_d[k] = GW_PEND;
            GW_PEND:   if (rd && reg_addr_i == A_CLAIM && win_vld && win_id == 4'(k + 1))
                          gw_d[k] = GW_FLIGHT;
            GW_FLIGHT: if (wr && reg_addr_i == A_CLAIM && reg_wdata_i == DW'(k + 1))
                          gw_d[k] = GW_IDLE;
            default:   gw_d[k] = GW_IDLE;
         endcase
      end

      if (wr) begin
         case (reg_addr_i)
            A_EN:    en_d  = reg_wdata_i[NUM_SRC-1:0];
            A_THR:   thr_d = reg_wdata_i[PRIO_W-1:0];
            default: begin
               for (int k = 0; k < NPRIO; k++)
                  if (reg_addr_i == 4'(k)) prio_d[k] = reg_wdata_i[PRIO_W-1:0];
            end
         endcase
      end

      if (rd) begin
         case (reg_addr_i)
            A_PEND:  rdata_d = DW'(pend_vec);
            A_EN:    rdata_d = DW'(en_q);
            A_THR:   rdata_d = DW'(thr_q);
            A_CLAIM: rdata_d = DW'(win_id);
            default: begin
               for (int k = 0; k < NPRIO; k++)
                  if (reg_addr_i == 4'(k)) rdata_d = DW'(prio_q[k]);
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            gw_q[k]   <= GW_IDLE;
            prio_q[k] <= '0;
         end
         en_q    <= '0;
         thr_q   <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         irq_q   <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_SRC; k++) begin
            gw_q[k]   <= gw_d[k];
            prio_q[k] <= prio_d[k];
         end
         en_q    <= en_d;
         thr_q   <= thr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         irq_q   <= win_vld;
         act_q   <= 1'b1;
      end
   end

   assign reg_rdata_o = rdata_q;
   assign reg_ready_o = ready_q;
   assign ext_irq_o   = irq_q;

endmodule
